div_seq: RTL and testbench
==========================

# div_seq

Sequential signed 32-bit divider for the multicycle CPU datapath. It answers the control unit's start/stop handshake in the same way the multiplier does, and returns the quotient and remainder to the HI/LO input muxes. It raises a divide-by-zero flag that the control unit uses as its exception trigger.

## Interface
- No parameters. Width is fixed at 32 bits and the iteration count is fixed at 32.
- `clk  in  1` : system clock. All state changes on the rising edge.
- `reset  in  1` : asynchronous, active-high reset.
- `A  in  32` : dividend, taken from the A register output. Signed two's complement.
- `B  in  32` : divisor, taken from the B register output. Signed two's complement.
- `DivInit  in  1` : start request from the control unit. Sampled only in IDLE.
- `DivStop  out  1` : done pulse. High for exactly one cycle when `Hi`/`Lo` become valid.
- `Div_Zero  out  1` : divide-by-zero pulse. High for exactly one cycle.
- `Div_Busy  out  1` : high in every state except IDLE.
- `Hi  out  32` : remainder. Registered.
- `Lo  out  32` : quotient. Registered.

## Operation
- States are IDLE, RUN, FIX and DONE.
- IDLE:
  - On `DivInit`=1 with `B`≠0, latch `A` and `B` (|A|, |B|, sign of quotient = A[31]^B[31], sign of remainder = A[31]), clear the 6-bit counter, and go to RUN.
  - On `DivInit`=1 with `B`=0, latch nothing and stay in IDLE; `Div_Zero` is high in the next cycle only. `Hi`, `Lo` and `DivStop` are unaffected.
- RUN performs one restoring-division step per cycle on unsigned magnitudes:
  - rem = {rem[31:0], quo[31]}, quo <<= 1.
  - If rem ≥ |B|: rem −= |B| and quo[0] = 1.
  - Use a 33-bit remainder datapath so that |A| = 2^31 is handled.
  - Counter increments each cycle. After the 32nd step, go to FIX.
- FIX: negate the quotient if the quotient sign is 1, negate the remainder if the remainder sign is 1, then write the results to `Lo`/`Hi`. Go to DONE.
- DONE: `DivStop`=1 (Moore output). Go to IDLE.
- Semantics: the quotient truncates toward zero, and the remainder takes the sign of the dividend (A = Lo·B + Hi).
- Overflow case 0x80000000 / 0xFFFFFFFF gives `Lo`=0x80000000, `Hi`=0. No flag is raised.
- `DivInit` is ignored in RUN, FIX and DONE; a request is never queued.
- Changes on `A`/`B` after the sampling edge have no effect.
- `Hi`/`Lo` hold their last result until the next FIX. They are not cleared at the start of a new operation.

## Timing
- Reset values: state = IDLE, `Hi`=0, `Lo`=0, `DivStop`=0, `Div_Zero`=0, `Div_Busy`=0, and all internal registers 0.
- Reset asserted mid-operation aborts immediately. No `DivStop` or `Div_Zero` follows. After reset is released, the first `DivInit` is accepted normally.
- If `DivInit` is high in cycle T (B≠0):
  - `Div_Busy` is high in cycles T+1 to T+34.
  - RUN occupies T+1 to T+32, FIX is T+33, DONE is T+34.
  - `DivStop`=1 in T+34, and `Hi`/`Lo` are valid from T+34 onward.
  - `DivStop` stays high for one cycle only.
- `DivInit` in T with B=0: `Div_Zero`=1 in T+1 only, and `Div_Busy` stays 0.
- Earliest next accepted `DivInit` is T+35, when the state is back in IDLE.
- If `DivInit` is held high continuously, a new division starts at every IDLE visit.
- `DivStop` and `Div_Zero` are never high in the same cycle.

## Test plan
- A=7, B=2, pulse `DivInit` at T. Required: `DivStop` only at T+34, `Lo`=0x00000003, `Hi`=0x00000001, `Div_Busy` high T+1..T+34.
- A=−7 (0xFFFFFFF9), B=2. Required: `Lo`=0xFFFFFFFD, `Hi`=0xFFFFFFFF. Repeat with A=7, B=−2: `Lo`=0xFFFFFFFD, `Hi`=0x00000001.
- A=0x80000000, B=0xFFFFFFFF. Required: `Lo`=0x80000000, `Hi`=0, `DivStop` at T+34.
- Preload `Hi`/`Lo` with the result of 100/7 (14, 2), then A=5, B=0. Required: `Div_Zero`=1 at T+1 only, no `DivStop` for the following 40 cycles, `Hi`=2 and `Lo`=14 unchanged.
- Start 100/7, then assert `reset` at T+10 for 2 cycles. Required: all outputs 0 immediately and no `DivStop` afterward. A new 100/7 started after release gives `Lo`=14, `Hi`=2 at its own T'+34.
- Start 20/3 at T, then pulse `DivInit` at T+5 with A=1, B=1. Required: the second request is ignored, `DivStop` occurs only at T+34, with `Lo`=6, `Hi`=2.

Source files
------------

// File: rtl/div_seq_if.sv
// Handshake and data bundle between the control unit and the sequential divider.
interface div_seq_if;
   logic signed [31:0] A;
   logic signed [31:0] B;
   logic               DivInit;
   logic               DivStop;
   logic               Div_Zero;
   logic               Div_Busy;
   logic signed [31:0] Hi;
   logic signed [31:0] Lo;

   modport master (output A, B, DivInit,
                   input  DivStop, Div_Zero, Div_Busy, Hi, Lo);
   modport slave  (input  A, B, DivInit,
                   output DivStop, Div_Zero, Div_Busy, Hi, Lo);
endinterface

// File: rtl/div_seq.sv
// Sequential signed 32-bit restoring divider: 32 magnitude steps, then a sign fix-up.
// Quotient truncates toward zero and the remainder takes the dividend's sign.
module div_seq (
   input  logic      clk,
   input  logic      reset,
   div_seq_if.slave  d
);
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t            state;
   logic [DATA_W-1:0] quo;
   logic [DATA_W-1:0] dvs;
   logic [DATA_W-1:0] rem;
   logic [5:0]        cnt;
   logic              q_neg;
   logic              r_neg;

   logic [DATA_W:0]   rem_sh;
   logic [DATA_W-1:0] rem_sub;
   logic              fits;

   function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] v);
      logic [DATA_W-1:0] u;
      u = v;
      return v[DATA_W-1] ? (~u + 1'b1) : u;
   endfunction

   function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v, input logic s);
      return s ? (~v + 1'b1) : v;
   endfunction

   // Shifted partial remainder needs 33 bits; after a successful subtract it fits in 32 again.
   always_comb begin
      rem_sh  = {rem, quo[DATA_W-1]};
      fits    = (rem_sh >= {1'b0, dvs});
      rem_sub = rem_sh[DATA_W-1:0] - dvs;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         quo        <= '0;
         dvs        <= '0;
         rem        <= '0;
         cnt        <= '0;
         q_neg      <= 1'b0;
         r_neg      <= 1'b0;
         d.Hi       <= '0;
         d.Lo       <= '0;
         d.DivStop  <= 1'b0;
         d.Div_Zero <= 1'b0;
         d.Div_Busy <= 1'b0;
      end else begin
         d.DivStop  <= 1'b0;
         d.Div_Zero <= 1'b0;
         case (state)
            IDLE: begin
               if (d.DivInit) begin
                  if (d.B == '0) begin
                     d.Div_Zero <= 1'b1;
                  end else begin
                     quo        <= mag(d.A);
                     dvs        <= mag(d.B);
                     rem        <= '0;
                     cnt        <= '0;
                     q_neg      <= d.A[DATA_W-1] ^ d.B[DATA_W-1];
                     r_neg      <= d.A[DATA_W-1];
                     d.Div_Busy <= 1'b1;
                     state      <= RUN;
                  end
               end
            end
            RUN: begin
               rem <= fits ? rem_sub : rem_sh[DATA_W-1:0];
               quo <= {quo[DATA_W-2:0], fits};
               cnt <= cnt + 6'd1;
               if (cnt == 6'd31)
                  state <= FIX;
            end
            FIX: begin
               d.Lo      <= neg_if(quo, q_neg);
               d.Hi      <= neg_if(rem, r_neg);
               d.DivStop <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               d.Div_Busy <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: a 64-bit reference model feeds a result queue that is
// drained when DivStop is seen, with cycle-accurate Busy/DivStop/Div_Zero checks.
module tb_div_seq;
   logic clk = 1'b0;
   logic reset;
   div_seq_if bus ();

   div_seq dut (.clk(clk), .reset(reset), .d(bus));

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   logic [63:0] sb[$];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      vectors++;
      assert (obs === req) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, req);
      end
   endtask

   function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
      longint sa, sd, q, r;
      sa = longint'($signed(a));
      sd = longint'($signed(b));
      q  = sa / sd;
      r  = sa % sd;
      return {r[31:0], q[31:0]};
   endfunction

   // Drives DivInit for one cycle (cycle T) and returns in cycle T+1.
   task automatic start_div(input logic [31:0] a, input logic [31:0] b);
      bus.A = a;
      bus.B = b;
      bus.DivInit = 1'b1;
      sb.push_back(model(a, b));
      step();
      bus.DivInit = 1'b0;
   endtask

   // Called in cycle T+k0; checks every cycle up to T+35.
   task automatic wait_done(input int k0);
      logic [63:0] e;
      for (int k = k0; k <= 34; k++) begin
         chk($sformatf("busy@T+%0d", k), 32'(bus.Div_Busy), 32'd1);
         chk($sformatf("stop@T+%0d", k), 32'(bus.DivStop), (k == 34) ? 32'd1 : 32'd0);
         chk($sformatf("zero@T+%0d", k), 32'(bus.Div_Zero), 32'd0);
         if (k == 34) begin
            if (sb.size() == 0) begin
               chk("scoreboard_empty", 32'd0, 32'd1);
            end else begin
               e = sb.pop_front();
               chk("Hi", bus.Hi, e[63:32]);
               chk("Lo", bus.Lo, e[31:0]);
            end
         end else begin
            step();
         end
      end
      step();
      chk("busy@T+35", 32'(bus.Div_Busy), 32'd0);
      chk("stop@T+35", 32'(bus.DivStop), 32'd0);
   endtask

   initial begin
      int stops;
      reset = 1'b1;
      bus.A = '0;
      bus.B = '0;
      bus.DivInit = 1'b0;
      step();
      step();
      reset = 1'b0;
      step();
      chk("rst_Hi", bus.Hi, 32'd0);
      chk("rst_Lo", bus.Lo, 32'd0);
      chk("rst_stop", 32'(bus.DivStop), 32'd0);
      chk("rst_zero", 32'(bus.Div_Zero), 32'd0);
      chk("rst_busy", 32'(bus.Div_Busy), 32'd0);

      start_div(32'd7, 32'd2);
      wait_done(1);
      start_div(32'hFFFF_FFF9, 32'd2);
      wait_done(1);
      start_div(32'd7, 32'hFFFF_FFFE);
      wait_done(1);
      start_div(32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(1);

      // Preload 100/7, then divide by zero: results must be left untouched.
      start_div(32'd100, 32'd7);
      wait_done(1);
      bus.A = 32'd5;
      bus.B = 32'd0;
      bus.DivInit = 1'b1;
      step();
      bus.DivInit = 1'b0;
      chk("dz_zero@T+1", 32'(bus.Div_Zero), 32'd1);
      chk("dz_busy@T+1", 32'(bus.Div_Busy), 32'd0);
      chk("dz_stop@T+1", 32'(bus.DivStop), 32'd0);
      step();
      chk("dz_zero@T+2", 32'(bus.Div_Zero), 32'd0);
      stops = 0;
      for (int i = 0; i < 40; i++) begin
         stops += int'(bus.DivStop) + int'(bus.Div_Zero) + int'(bus.Div_Busy);
         step();
      end
      chk("dz_quiet", 32'(stops), 32'd0);
      chk("dz_Hi", bus.Hi, 32'd2);
      chk("dz_Lo", bus.Lo, 32'd14);

      // Abort mid-operation with reset.
      start_div(32'd100, 32'd7);
      repeat (9) step();
      reset = 1'b1;
      #1;
      chk("abort_Hi", bus.Hi, 32'd0);
      chk("abort_Lo", bus.Lo, 32'd0);
      chk("abort_busy", 32'(bus.Div_Busy), 32'd0);
      chk("abort_stop", 32'(bus.DivStop), 32'd0);
      chk("abort_zero", 32'(bus.Div_Zero), 32'd0);
      sb.delete();
      step();
      step();
      reset = 1'b0;
      stops = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         stops += int'(bus.DivStop) + int'(bus.Div_Zero);
      end
      chk("abort_no_stop", 32'(stops), 32'd0);
      start_div(32'd100, 32'd7);
      wait_done(1);

      // A second request during RUN is dropped; operand changes do not leak in.
      start_div(32'd20, 32'd3);
      for (int k = 1; k <= 4; k++) begin
         chk($sformatf("ign_busy@T+%0d", k), 32'(bus.Div_Busy), 32'd1);
         step();
      end
      bus.A = 32'd1;
      bus.B = 32'd1;
      bus.DivInit = 1'b1;
      step();
      bus.DivInit = 1'b0;
      wait_done(6);

      // DivInit held high: a new division starts at the next IDLE visit.
      bus.A = 32'd9;
      bus.B = 32'd4;
      bus.DivInit = 1'b1;
      sb.push_back(model(32'd9, 32'd4));
      step();
      bus.A = 32'hFFFF_FFF7;
      sb.push_back(model(32'hFFFF_FFF7, 32'd4));
      wait_done(1);
      step();
      bus.DivInit = 1'b0;
      wait_done(1);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
